// File: rtl/switch_input_conditioner.sv
// Switch front-end: synchronizes the four raw sensor switches and debounces
// them as one vector. A changed vector is committed only after it has held for
// DEBOUNCE_CYCLES cycles, and each commit emits a one-cycle sample_valid strobe.
module switch_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_raw_1,
  input  logic sw_raw_2,
  input  logic sw_raw_3,
  input  logic sw_raw_4,
  output logic switch_1,
  output logic switch_2,
  output logic switch_3,
  output logic switch_4,
  output logic sample_valid,
  output logic busy
);

  localparam int unsigned VEC_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SETTLE = 1'b1
  } state_t;

  logic [VEC_W-1:0] w_raw;
  logic [VEC_W-1:0] r_sync1;
  logic [VEC_W-1:0] r_sync2;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [VEC_W-1:0] r_q;
  logic [VEC_W-1:0] w_q_nxt;
  logic [VEC_W-1:0] r_cand;
  logic [VEC_W-1:0] w_cand_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_valid;
  logic             w_valid_nxt;
  logic             r_busy;
  logic             w_busy_nxt;

  // Bit order {1,2,3,4}: switch 1 is the MSB of the vector.
  assign w_raw = {sw_raw_1, sw_raw_2, sw_raw_3, sw_raw_4};

  // Two-flop synchronizer on every raw bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // State register together with the committed vector, candidate and counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_q     <= '0;
      r_cand  <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_cand  <= w_cand_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Next-state logic; in SETTLE a return to the committed value wins first,
  // then a bounce to a new candidate, and only then the commit.
  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_cand_nxt  = r_cand;
    w_cnt_nxt   = r_cnt;
    w_valid_nxt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (r_sync2 != r_q) begin
          w_cand_nxt  = r_sync2;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (r_sync2 == r_q) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else if (r_sync2 != r_cand) begin
          w_cand_nxt = r_sync2;
          w_cnt_nxt  = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_q_nxt     = r_cand;
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt == ST_SETTLE);
  end

  assign switch_1     = r_q[3];
  assign switch_2     = r_q[2];
  assign switch_3     = r_q[1];
  assign switch_4     = r_q[0];
  assign sample_valid = r_valid;
  assign busy         = r_busy;

endmodule

// File: tb/tb_switch_input_conditioner.sv
// Bench for switch_input_conditioner: scenario tasks push expected commits
// (vector, edge number) into a queue; a monitor records observed strobes.
module tb_switch_input_conditioner;

  localparam int D = 4;

  typedef struct {
    logic [3:0] vec;
    int         cyc_n;
  } ev_t;

  logic clk;
  logic rst_n;
  logic sw_raw_1, sw_raw_2, sw_raw_3, sw_raw_4;
  logic switch_1, switch_2, switch_3, switch_4;
  logic sample_valid;
  logic busy;

  int  cyc;
  int  n_checks;
  int  n_fail;
  int  n_double;
  logic prev_valid;

  ev_t exp_q[$];
  ev_t obs_q[$];

  wire [3:0] sw_vec = {switch_1, switch_2, switch_3, switch_4};

  switch_input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw_raw_1    (sw_raw_1),
    .sw_raw_2    (sw_raw_2),
    .sw_raw_3    (sw_raw_3),
    .sw_raw_4    (sw_raw_4),
    .switch_1    (switch_1),
    .switch_2    (switch_2),
    .switch_3    (switch_3),
    .switch_4    (switch_4),
    .sample_valid(sample_valid),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: after rising edge k, cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe with the committed vector and the edge it followed.
  always @(negedge clk) begin
    if (rst_n && sample_valid) begin
      obs_q.push_back('{vec: sw_vec, cyc_n: cyc});
    end
    if (sample_valid && prev_valid) n_double <= n_double + 1;
    prev_valid <= sample_valid;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic set_raw(input logic [3:0] v);
    {sw_raw_1, sw_raw_2, sw_raw_3, sw_raw_4} = v;
  endtask

  task automatic do_reset(input logic [3:0] v);
    set_raw(v);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(D + 6);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset;
    ev_t e, o;
    int  r;
    set_raw(4'b1111);
    rst_n = 1'b0;
    tick(3);
    n_checks++;
    if (sw_vec !== 4'b0000) begin n_fail++; $display("FAIL reset_switch: got %b want 0000", sw_vec); end
    n_checks++;
    if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", sample_valid); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    obs_q.delete();
    rst_n = 1'b1;
    r = cyc + 1;
    exp_q.push_back('{vec: 4'b1111, cyc_n: r + D + 2});
    tick(D + 8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL reset_commit: no strobe, want %b at edge %0d", e.vec, e.cyc_n);
      end else begin
        o = obs_q.pop_front();
        if (o.vec !== e.vec || o.cyc_n != e.cyc_n) begin
          n_fail++; $display("FAIL reset_commit: got %b@%0d want %b@%0d", o.vec, o.cyc_n, e.vec, e.cyc_n);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL reset_extra: %0d extra strobes, want 0", obs_q.size()); end
    n_checks++;
    if (sw_vec !== 4'b1111) begin n_fail++; $display("FAIL reset_final: got %b want 1111", sw_vec); end
  endtask

  task automatic test_clean_step;
    ev_t e, o;
    int  n, k;
    do_reset(4'b0000);
    set_raw(4'b0011);
    n = cyc + 1;
    exp_q.push_back('{vec: 4'b0011, cyc_n: n + D + 2});
    for (int i = 0; i <= 8; i++) begin
      tick(1);
      k = cyc - n;
      n_checks++;
      if (busy !== ((k >= 2 && k <= 5) ? 1'b1 : 1'b0)) begin
        n_fail++; $display("FAIL step_busy: edge N+%0d got %b", k, busy);
      end
      n_checks++;
      if (sample_valid !== ((k == 6) ? 1'b1 : 1'b0)) begin
        n_fail++; $display("FAIL step_valid: edge N+%0d got %b", k, sample_valid);
      end
      n_checks++;
      if (sw_vec !== ((k >= 6) ? 4'b0011 : 4'b0000)) begin
        n_fail++; $display("FAIL step_switch: edge N+%0d got %b", k, sw_vec);
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL step_commit: no strobe, want %b at edge %0d", e.vec, e.cyc_n);
      end else begin
        o = obs_q.pop_front();
        if (o.vec !== e.vec || o.cyc_n != e.cyc_n) begin
          n_fail++; $display("FAIL step_commit: got %b@%0d want %b@%0d", o.vec, o.cyc_n, e.vec, e.cyc_n);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL step_extra: %0d extra strobes, want 0", obs_q.size()); end
  endtask

  task automatic test_glitch;
    do_reset(4'b0000);
    set_raw(4'b0100);
    tick(2);
    set_raw(4'b0000);
    tick(1);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_rise: got %b want 1", busy); end
    tick(10);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_fall: got %b want 0", busy); end
    n_checks++;
    if (sw_vec !== 4'b0000) begin n_fail++; $display("FAIL glitch_switch: got %b want 0000", sw_vec); end
    n_checks++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL glitch_strobe: %0d strobes, want 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_bounce;
    ev_t e, o;
    int  last;
    logic [3:0] pat [5];
    pat[0] = 4'b1000; pat[1] = 4'b1001; pat[2] = 4'b1000; pat[3] = 4'b1001; pat[4] = 4'b1000;
    do_reset(4'b0000);
    last = 0;
    for (int i = 0; i < 5; i++) begin
      set_raw(pat[i]);
      last = cyc + 1;
      tick(2);
    end
    exp_q.push_back('{vec: 4'b1000, cyc_n: last + D + 2});
    tick(12);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL bounce_commit: no strobe, want %b at edge %0d", e.vec, e.cyc_n);
      end else begin
        o = obs_q.pop_front();
        if (o.vec !== e.vec || o.cyc_n != e.cyc_n) begin
          n_fail++; $display("FAIL bounce_commit: got %b@%0d want %b@%0d", o.vec, o.cyc_n, e.vec, e.cyc_n);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL bounce_extra: %0d extra strobes, want 0", obs_q.size()); end
    n_checks++;
    if (sw_vec !== 4'b1000) begin n_fail++; $display("FAIL bounce_switch: got %b want 1000", sw_vec); end
  endtask

  task automatic test_sweep;
    ev_t e, o;
    int  n;
    logic [3:0] v;
    do_reset(4'b0000);
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      set_raw(v);
      n = cyc + 1;
      if (i != 0) exp_q.push_back('{vec: v, cyc_n: n + D + 2});
      tick(D + 4);
      n_checks++;
      if (sw_vec !== v) begin n_fail++; $display("FAIL sweep_switch: got %b want %b", sw_vec, v); end
    end
    n_checks++;
    if (obs_q.size() != 15) begin n_fail++; $display("FAIL sweep_count: got %0d strobes want 15", obs_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL sweep_commit: no strobe, want %b at edge %0d", e.vec, e.cyc_n);
      end else begin
        o = obs_q.pop_front();
        if (o.vec !== e.vec || o.cyc_n != e.cyc_n) begin
          n_fail++; $display("FAIL sweep_commit: got %b@%0d want %b@%0d", o.vec, o.cyc_n, e.vec, e.cyc_n);
        end
      end
    end
    obs_q.delete();
  endtask

  task automatic test_reset_mid_settle;
    ev_t e, o;
    int  n, r;
    bit  seen;
    do_reset(4'b0000);
    set_raw(4'b1111);
    n = cyc + 1;
    exp_q.push_back('{vec: 4'b1111, cyc_n: n + D + 2});
    tick(D + 4);
    set_raw(4'b0110);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick(1);
      if (busy === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL midrst_busy: busy never rose within 10 cycles"); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (sw_vec !== 4'b0000) begin n_fail++; $display("FAIL midrst_switch: got %b want 0000", sw_vec); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy_clr: got %b want 0", busy); end
    tick(1);
    rst_n = 1'b1;
    r = cyc + 1;
    exp_q.push_back('{vec: 4'b0110, cyc_n: r + D + 2});
    tick(D + 8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL midrst_commit: no strobe, want %b at edge %0d", e.vec, e.cyc_n);
      end else begin
        o = obs_q.pop_front();
        if (o.vec !== e.vec || o.cyc_n != e.cyc_n) begin
          n_fail++; $display("FAIL midrst_commit: got %b@%0d want %b@%0d", o.vec, o.cyc_n, e.vec, e.cyc_n);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL midrst_extra: %0d extra strobes, want 0", obs_q.size()); end
    n_checks++;
    if (sw_vec !== 4'b0110) begin n_fail++; $display("FAIL midrst_final: got %b want 0110", sw_vec); end
  endtask

  task automatic test_back_to_back;
    ev_t e, o;
    int  n, m;
    do_reset(4'b0000);
    // New difference reaches s on the edge right after a commit.
    set_raw(4'b0001);
    n = cyc + 1;
    exp_q.push_back('{vec: 4'b0001, cyc_n: n + D + 2});
    tick(5);
    set_raw(4'b0010);
    m = cyc + 1;
    exp_q.push_back('{vec: 4'b0010, cyc_n: m + D + 2});
    tick(2);
    n_checks++;
    if (sample_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_commit_edge: got %b want 1", sample_valid); end
    tick(1);
    n_checks++;
    if (busy !== 1'b1 || sample_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_resettle: busy %b valid %b want 1 0", busy, sample_valid);
    end
    tick(8);
    // Change lands in s exactly on the would-be commit edge: 0100 never commits.
    set_raw(4'b0100);
    tick(4);
    set_raw(4'b1000);
    m = cyc + 1;
    exp_q.push_back('{vec: 4'b1000, cyc_n: m + D + 2});
    tick(12);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL b2b_commit: no strobe, want %b at edge %0d", e.vec, e.cyc_n);
      end else begin
        o = obs_q.pop_front();
        if (o.vec !== e.vec || o.cyc_n != e.cyc_n) begin
          n_fail++; $display("FAIL b2b_commit: got %b@%0d want %b@%0d", o.vec, o.cyc_n, e.vec, e.cyc_n);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL b2b_extra: %0d extra strobes, want 0", obs_q.size()); end
    n_checks++;
    if (sw_vec !== 4'b1000) begin n_fail++; $display("FAIL b2b_final: got %b want 1000", sw_vec); end
  endtask

  initial begin
    cyc        = 0;
    n_checks   = 0;
    n_fail     = 0;
    n_double   = 0;
    prev_valid = 1'b0;
    rst_n      = 1'b0;
    set_raw(4'b0000);

    test_reset();
    test_clean_step();
    test_glitch();
    test_bounce();
    test_sweep();
    test_reset_mid_settle();
    test_back_to_back();

    n_checks++;
    if (n_double != 0) begin n_fail++; $display("FAIL strobe_width: %0d consecutive-cycle strobes, want 0", n_double); end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
